fifo: RTL and testbench
=======================

# fifo

Single-clock synchronous FIFO buffer with a registered read port, an occupancy counter and full/empty status flags. It decouples a producer and a consumer in the same clock domain. Typical uses are stream buffering between pipeline stages or absorbing short bursts. Default depth is 64 entries of 8 bits.

## Interface
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 6, log2 of depth; DEPTH = 2^ADDR_WIDTH; legal range 1..7.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- wr_en  input  1  write request; buf_in stored at the edge if not full.
- rd_en  input  1  read request; oldest word moved to buf_out at the edge if not empty.
- buf_in  input  DATA_WIDTH  write data.
- buf_out  output  DATA_WIDTH  registered read data.
- fifo_counter  output  8  current occupancy, 0..DEPTH.
- buf_empty  output  1  high when fifo_counter == 0.
- buf_full  output  1  high when fifo_counter == DEPTH.

## Operation
- Storage: DEPTH x DATA_WIDTH array, write pointer and read pointer, each ADDR_WIDTH bits, plus an occupancy counter.
- Write accepted = wr_en && !buf_full: mem[wr_ptr] <= buf_in; wr_ptr increments.
- Read accepted = rd_en && !buf_empty: buf_out <= mem[rd_ptr]; rd_ptr increments.
- Counter: +1 on write-only, -1 on read-only, unchanged when both or neither are accepted.
- Flags are combinational decodes of fifo_counter, evaluated from the pre-edge state.
- Write while full: dropped; memory, pointers and counter unchanged.
- Read while empty: ignored; buf_out holds its last value.
- wr_en and rd_en together:
  - empty: write only, counter +1, buf_out holds.
  - full: read only, counter -1, buf_in dropped.
  - otherwise: both happen, counter unchanged.
- Pointers wrap modulo DEPTH naturally; no special wrap logic.
- Strict FIFO order: reads return words in write order.
- Memory contents are not reset.

## Timing
- Reset: on any edge with rst=1, wr_ptr=0, rd_ptr=0, fifo_counter=0, buf_out=0, buf_empty=1, buf_full=0.
- Reset overrides wr_en and rd_en in the same cycle. Reset mid-operation discards all stored data.
- Write to read latency:
  - A word written at edge N is readable from edge N+1.
  - A read accepted at edge M presents the data on buf_out after edge M.
- Flags and fifo_counter update in the same cycle as the accepted access; no extra latency.
- buf_full asserts the cycle after the 64th unread write (default config).
- buf_empty asserts the cycle after the last stored word is read.
- No write-through: a simultaneous read at empty never returns the word being written.

## Configuration
- Macro: FIFO_ERR_FLAGS_EN.
- Defined: adds two outputs.
  - overflow (1 bit): sticky, sets on wr_en while buf_full.
  - underflow (1 bit): sticky, sets on rd_en while buf_empty.
  - Both clear only on rst and reset to 0.
- Not defined: these ports and their logic are absent. Core behaviour is identical in both builds.

## Test plan
- Reset held 50 ns, then released: buf_empty=1, buf_full=0, fifo_counter=0, buf_out=0.
- Write 0x01..0x0A on 10 consecutive cycles: fifo_counter reaches 10, buf_empty=0.
- Read 10 times: buf_out shows 0x01..0x0A in order, fifo_counter returns to 0, buf_empty=1. An extra rd_en leaves buf_out=0x0A.
- Write incrementing data until buf_full: buf_full asserts with fifo_counter=64. One more write is dropped; with FIFO_ERR_FLAGS_EN, overflow=1. Then read all 64 words in order, including across pointer wrap, until buf_empty with fifo_counter=0.
- From empty, drive wr_en=rd_en=1 for 10 cycles with buf_in 0xA1..0xAA:
  - first cycle write only, fifo_counter becomes 1;
  - then fifo_counter stays 1 and buf_out lags one word (0xA1, 0xA2, ...).
- Assert rst with 5 words stored and wr_en/rd_en active: the next cycle shows fifo_counter=0, buf_empty=1, buf_out=0, and the stored words are no longer readable.

Source files
------------

// File: rtl/fifo.sv
// Single-clock FIFO with registered read port, occupancy counter and status flags; FIFO_ERR_FLAGS_EN adds sticky overflow/underflow.
// Write-to-read latency one edge; writes while full are dropped, reads while empty are ignored.
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] buf_in,
    output logic [DATA_WIDTH-1:0] buf_out,
    output logic [7:0]            fifo_counter,
    output logic                  buf_empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                  buf_full,
    output logic                  overflow,
    output logic                  underflow
`else
    output logic                  buf_full
`endif
);

    localparam int          DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [7:0]  DEPTH_CNT = 8'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  wr_ok, rd_ok;

    assign buf_empty    = (cnt_q == 8'd0);
    assign buf_full     = (cnt_q == DEPTH_CNT);
    assign fifo_counter = cnt_q;
    assign buf_out      = dout_q;

    assign wr_ok = wr_en && !buf_full;
    assign rd_ok = rd_en && !buf_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            dout_d   = mem_q[rd_ptr_q];
        end
        if (wr_ok && !rd_ok) begin
            cnt_d = cnt_q + 8'd1;
        end else if (rd_ok && !wr_ok) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers make stale words unreachable.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem_q[wr_ptr_q] <= buf_in;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr_en && buf_full)  ovf_q <= 1'b1;
            if (rd_en && buf_empty) unf_q <= 1'b1;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// Directed bench for fifo: reset, fill/drain, full/empty boundaries, pointer wrap, simultaneous access, mid-run reset.
`timescale 1ns/1ps
module tb_fifo;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] buf_in;
    logic [7:0] buf_out;
    logic [7:0] fifo_counter;
    logic       buf_empty;
    logic       buf_full;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif

    int compared   = 0;
    int mismatched = 0;

    fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .buf_in       (buf_in),
        .buf_out      (buf_out),
        .fifo_counter (fifo_counter),
        .buf_empty    (buf_empty),
`ifdef FIFO_ERR_FLAGS_EN
        .buf_full     (buf_full),
        .overflow     (overflow),
        .underflow    (underflow)
`else
        .buf_full     (buf_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; buf_in = 8'h00;
        #50;
        tick();
        rst = 1'b0;
        tick();
        compared++;
        if (buf_empty !== 1'b1) begin mismatched++; $display("FAIL reset_empty: got %b want 1", buf_empty); end
        compared++;
        if (buf_full !== 1'b0) begin mismatched++; $display("FAIL reset_full: got %b want 0", buf_full); end
        compared++;
        if (fifo_counter !== 8'd0) begin mismatched++; $display("FAIL reset_count: got %0d want 0", fifo_counter); end
        compared++;
        if (buf_out !== 8'h00) begin mismatched++; $display("FAIL reset_out: got %h want 00", buf_out); end
`ifdef FIFO_ERR_FLAGS_EN
        compared++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            mismatched++; $display("FAIL reset_errflags: got %b%b want 00", overflow, underflow);
        end
`endif
    endtask

    task automatic test_write10();
        for (int i = 1; i <= 10; i++) begin
            wr_en = 1'b1; buf_in = 8'(i);
            tick();
            compared++;
            if (fifo_counter !== 8'(i)) begin mismatched++; $display("FAIL write10_count: got %0d want %0d", fifo_counter, i); end
        end
        wr_en = 1'b0;
        compared++;
        if (buf_empty !== 1'b0) begin mismatched++; $display("FAIL write10_empty: got %b want 0", buf_empty); end
    endtask

    task automatic test_read10();
        for (int i = 1; i <= 10; i++) begin
            rd_en = 1'b1;
            tick();
            compared++;
            if (buf_out !== 8'(i)) begin mismatched++; $display("FAIL read10_data: got %h want %h", buf_out, 8'(i)); end
            compared++;
            if (fifo_counter !== 8'(10 - i)) begin mismatched++; $display("FAIL read10_count: got %0d want %0d", fifo_counter, 10 - i); end
        end
        compared++;
        if (buf_empty !== 1'b1) begin mismatched++; $display("FAIL read10_empty: got %b want 1", buf_empty); end
        tick();
        rd_en = 1'b0;
        compared++;
        if (buf_out !== 8'h0A) begin mismatched++; $display("FAIL underread_hold: got %h want 0a", buf_out); end
        compared++;
        if (fifo_counter !== 8'd0) begin mismatched++; $display("FAIL underread_count: got %0d want 0", fifo_counter); end
`ifdef FIFO_ERR_FLAGS_EN
        compared++;
        if (underflow !== 1'b1) begin mismatched++; $display("FAIL underflow_set: got %b want 1", underflow); end
`endif
    endtask

    task automatic test_full_wrap();
        for (int i = 0; i < 64; i++) begin
            compared++;
            if (buf_full !== 1'b0) begin mismatched++; $display("FAIL full_early: got %b want 0 at count %0d", buf_full, fifo_counter); end
            wr_en = 1'b1; buf_in = 8'(i + 16);
            tick();
        end
        compared++;
        if (buf_full !== 1'b1) begin mismatched++; $display("FAIL full_flag: got %b want 1", buf_full); end
        compared++;
        if (fifo_counter !== 8'd64) begin mismatched++; $display("FAIL full_count: got %0d want 64", fifo_counter); end
        buf_in = 8'hFF;
        tick();
        wr_en = 1'b0;
        compared++;
        if (fifo_counter !== 8'd64 || buf_full !== 1'b1) begin
            mismatched++; $display("FAIL overwrite_drop: got count %0d full %b want 64 1", fifo_counter, buf_full);
        end
`ifdef FIFO_ERR_FLAGS_EN
        compared++;
        if (overflow !== 1'b1) begin mismatched++; $display("FAIL overflow_set: got %b want 1", overflow); end
`endif
        for (int i = 0; i < 64; i++) begin
            rd_en = 1'b1;
            tick();
            compared++;
            if (buf_out !== 8'(i + 16)) begin mismatched++; $display("FAIL wrap_data: got %h want %h", buf_out, 8'(i + 16)); end
        end
        rd_en = 1'b0;
        compared++;
        if (buf_empty !== 1'b1 || fifo_counter !== 8'd0) begin
            mismatched++; $display("FAIL drain_end: got empty %b count %0d want 1 0", buf_empty, fifo_counter);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; buf_in = 8'(8'hA1 + i);
            tick();
            compared++;
            if (fifo_counter !== 8'd1) begin mismatched++; $display("FAIL b2b_count: got %0d want 1 (cycle %0d)", fifo_counter, i); end
            compared++;
            if (i == 0) begin
                if (buf_out !== 8'h4F) begin mismatched++; $display("FAIL b2b_nowt: got %h want 4f", buf_out); end
            end else begin
                if (buf_out !== 8'(8'hA0 + i)) begin mismatched++; $display("FAIL b2b_data: got %h want %h", buf_out, 8'(8'hA0 + i)); end
            end
        end
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; buf_in = 8'(8'hB1 + i);
            tick();
        end
        compared++;
        if (fifo_counter !== 8'd5) begin mismatched++; $display("FAIL mid_prefill: got %0d want 5", fifo_counter); end
        rst = 1'b1; wr_en = 1'b1; rd_en = 1'b1; buf_in = 8'hEE;
        tick();
        compared++;
        if (fifo_counter !== 8'd0 || buf_empty !== 1'b1 || buf_out !== 8'h00) begin
            mismatched++; $display("FAIL mid_reset: got count %0d empty %b out %h want 0 1 00", fifo_counter, buf_empty, buf_out);
        end
`ifdef FIFO_ERR_FLAGS_EN
        compared++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            mismatched++; $display("FAIL mid_errclr: got %b%b want 00", overflow, underflow);
        end
`endif
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b1;
        tick();
        compared++;
        if (buf_out !== 8'h00 || fifo_counter !== 8'd0) begin
            mismatched++; $display("FAIL mid_discard: got out %h count %0d want 00 0", buf_out, fifo_counter);
        end
        rd_en = 1'b0; wr_en = 1'b1; buf_in = 8'h5A;
        tick();
        wr_en = 1'b0; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        compared++;
        if (buf_out !== 8'h5A || buf_empty !== 1'b1) begin
            mismatched++; $display("FAIL post_reset_rw: got out %h empty %b want 5a 1", buf_out, buf_empty);
        end
    endtask

    initial begin
        test_reset();
        test_write10();
        test_read10();
        test_full_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
